// File: rtl/lfsr_sequence_checker.sv
// Receive-side checker for the 6-bit LFSR stream: self-synchronises from incoming
// words, declares lock, counts mismatches while locked and drops lock on sustained error.
module lfsr_sequence_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [5:0]       in_value,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             zero_seen,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

    state_e             state_q, state_d;
    logic [5:0]         pred_q, pred_d;
    logic [3:0]         good_cnt_q, good_cnt_d;
    logic [3:0]         bad_cnt_q, bad_cnt_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               zero_seen_q, zero_seen_d;

    function automatic logic [5:0] nxt(input logic [5:0] v);
        return {v[4:0], v[0] ^ v[1] ^ v[2] ^ v[4]};
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        state_d     = state_q;
        pred_d      = pred_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        zero_seen_d = zero_seen_q;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (in_value == 6'd0) begin
                        zero_seen_d = 1'b1;
                    end else begin
                        pred_d     = nxt(in_value);
                        good_cnt_d = 4'd0;
                        state_d    = SYNC;
                    end
                end
                SYNC: begin
                    if (in_value == 6'd0) begin
                        zero_seen_d = 1'b1;
                        state_d     = HUNT;
                    end else if (in_value == pred_q) begin
                        pred_d = nxt(in_value);
                        if (good_cnt_q + 4'd1 == LOCK_CNT) begin
                            state_d    = LOCKED;
                            good_cnt_d = 4'd0;
                            bad_cnt_d  = 4'd0;
                        end else begin
                            good_cnt_d = good_cnt_q + 4'd1;
                        end
                    end else begin
                        pred_d     = nxt(in_value);
                        good_cnt_d = 4'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction advances on its own, independent of the input.
                    pred_d = nxt(pred_q);
                    if (in_value == 6'd0) zero_seen_d = 1'b1;
                    if (in_value == pred_q && in_value != 6'd0) begin
                        bad_cnt_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                        if (bad_cnt_q + 4'd1 == LOSS_CNT) begin
                            state_d    = SYNC;
                            pred_d     = nxt(in_value);
                            good_cnt_d = 4'd0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (clear) begin
            err_count_d = '0;
            err_pulse_d = 1'b0;
        end

        locked_d = (state_d == LOCKED);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            pred_q      <= 6'd0;
            good_cnt_q  <= 4'd0;
            bad_cnt_q   <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            zero_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            zero_seen_q <= zero_seen_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign zero_seen = zero_seen_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Directed bench for lfsr_sequence_checker: lock acquisition, flywheel errors,
// loss and relock, idle cycles, zero words, saturation, clear and async reset.
module tb_lfsr_sequence_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [5:0] in_value;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       zero_seen;
    logic [1:0] state;

    int passed = 0;
    int total  = 0;

    lfsr_sequence_checker #(.LOCK_COUNT(3), .LOSS_COUNT(2), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_value  (in_value),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .zero_seen (zero_seen),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    function automatic logic [5:0] nxt(input logic [5:0] v);
        return {v[4:0], v[0] ^ v[1] ^ v[2] ^ v[4]};
    endfunction

    task automatic drive(input logic v, input logic [5:0] val, input logic clr);
        @(negedge clk);
        in_valid = v;
        in_value = val;
        clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_value = 6'd0;
        clear    = 1'b0;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic lock_up(input string tag);
        logic [5:0] words [4] = '{6'd63, 6'd62, 6'd61, 6'd59};
        logic [1:0] exp_st [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[i], 1'b0);
            total++;
            if (state !== exp_st[i])
                $display("FAIL %s_state[%0d]: got %0d expected %0d", tag, i, state, exp_st[i]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0b expected 0", locked); else passed++;
        total++; if (err_pulse !== 1'b0) $display("FAIL reset_err_pulse: got %0b expected 0", err_pulse); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d expected 0", err_count); else passed++;
        total++; if (zero_seen !== 1'b0) $display("FAIL reset_zero_seen: got %0b expected 0", zero_seen); else passed++;
    endtask

    task automatic test_lock();
        do_reset();
        lock_up("lock");
        total++; if (locked !== 1'b1) $display("FAIL lock_locked: got %0b expected 1", locked); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL lock_err_count: got %0d expected 0", err_count); else passed++;
    endtask

    // Continues from the locked state left by test_lock (prediction = 55).
    task automatic test_single_error();
        drive(1'b1, 6'd55, 1'b0);
        drive(1'b1, 6'd46, 1'b0);
        total++; if (err_pulse !== 1'b0) $display("FAIL single_no_pulse: got %0b expected 0", err_pulse); else passed++;
        drive(1'b1, 6'h15, 1'b0);
        total++; if (err_pulse !== 1'b1) $display("FAIL single_pulse: got %0b expected 1", err_pulse); else passed++;
        total++; if (err_count !== 8'd1) $display("FAIL single_err_count: got %0d expected 1", err_count); else passed++;
        total++; if (locked !== 1'b1) $display("FAIL single_locked: got %0b expected 1", locked); else passed++;
        drive(1'b1, 6'd56, 1'b0);
        total++; if (err_pulse !== 1'b0) $display("FAIL single_recover_pulse: got %0b expected 0", err_pulse); else passed++;
        total++; if (err_count !== 8'd1) $display("FAIL single_recover_count: got %0d expected 1", err_count); else passed++;
        // bad_cnt was cleared by the good word, so one more error must not drop lock.
        drive(1'b1, 6'd1, 1'b0);
        total++; if (err_count !== 8'd2) $display("FAIL single_second_count: got %0d expected 2", err_count); else passed++;
        total++; if (state !== 2'd2) $display("FAIL single_second_state: got %0d expected 2", state); else passed++;
        drive(1'b1, 6'd34, 1'b0);
        total++; if (err_pulse !== 1'b0) $display("FAIL single_good_after: got %0b expected 0", err_pulse); else passed++;
    endtask

    // Prediction is 5 here; two wrong words drop lock, reseed from 2 -> 5,10,21 relock.
    task automatic test_loss_relock();
        drive(1'b1, 6'd1, 1'b0);
        total++; if (err_count !== 8'd3) $display("FAIL loss_first_count: got %0d expected 3", err_count); else passed++;
        total++; if (locked !== 1'b1) $display("FAIL loss_first_locked: got %0b expected 1", locked); else passed++;
        drive(1'b1, 6'd2, 1'b0);
        total++; if (err_count !== 8'd4) $display("FAIL loss_second_count: got %0d expected 4", err_count); else passed++;
        total++; if (state !== 2'd1) $display("FAIL loss_state: got %0d expected 1", state); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL loss_locked: got %0b expected 0", locked); else passed++;
        drive(1'b1, 6'd5, 1'b0);
        total++; if (state !== 2'd1) $display("FAIL relock_s1: got %0d expected 1", state); else passed++;
        drive(1'b1, 6'd10, 1'b0);
        total++; if (state !== 2'd1) $display("FAIL relock_s2: got %0d expected 1", state); else passed++;
        drive(1'b1, 6'd21, 1'b0);
        total++; if (locked !== 1'b1) $display("FAIL relock_locked: got %0b expected 1", locked); else passed++;
        drive(1'b1, 6'd43, 1'b0);
        total++; if (err_pulse !== 1'b0) $display("FAIL relock_flywheel: got %0b expected 0", err_pulse); else passed++;
        total++; if (err_count !== 8'd4) $display("FAIL relock_count: got %0d expected 4", err_count); else passed++;
    endtask

    task automatic test_sync_reseed();
        do_reset();
        drive(1'b1, 6'd63, 1'b0);
        drive(1'b1, 6'd40, 1'b0);
        total++; if (state !== 2'd1) $display("FAIL reseed_state: got %0d expected 1", state); else passed++;
        total++; if (err_pulse !== 1'b0) $display("FAIL reseed_pulse: got %0b expected 0", err_pulse); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL reseed_count: got %0d expected 0", err_count); else passed++;
        drive(1'b1, 6'd16, 1'b0);
        drive(1'b1, 6'd32, 1'b0);
        drive(1'b1, 6'd0, 1'b0);
        total++; if (state !== 2'd0) $display("FAIL sync_zero_state: got %0d expected 0", state); else passed++;
        total++; if (zero_seen !== 1'b1) $display("FAIL sync_zero_seen: got %0b expected 1", zero_seen); else passed++;
    endtask

    task automatic test_idle();
        do_reset();
        drive(1'b1, 6'd63, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 6'd17, 1'b0);
            total++; if (state !== 2'd1) $display("FAIL idle_state[%0d]: got %0d expected 1", i, state); else passed++;
        end
        drive(1'b1, 6'd62, 1'b0);
        drive(1'b0, 6'd0, 1'b0);
        total++; if (zero_seen !== 1'b0) $display("FAIL idle_zero_ignored: got %0b expected 0", zero_seen); else passed++;
        drive(1'b1, 6'd61, 1'b0);
        drive(1'b0, 6'd3, 1'b0);
        drive(1'b1, 6'd59, 1'b0);
        total++; if (locked !== 1'b1) $display("FAIL idle_locked: got %0b expected 1", locked); else passed++;
        drive(1'b0, 6'd9, 1'b0);
        total++; if (state !== 2'd2) $display("FAIL idle_hold_locked: got %0d expected 2", state); else passed++;
        total++; if (err_pulse !== 1'b0) $display("FAIL idle_pulse: got %0b expected 0", err_pulse); else passed++;
        drive(1'b1, 6'd55, 1'b0);
        total++; if (err_pulse !== 1'b0) $display("FAIL idle_pred_held: got %0b expected 0", err_pulse); else passed++;
    endtask

    task automatic test_zero();
        do_reset();
        drive(1'b1, 6'd0, 1'b0);
        total++; if (zero_seen !== 1'b1) $display("FAIL zero_seen: got %0b expected 1", zero_seen); else passed++;
        total++; if (state !== 2'd0) $display("FAIL zero_state: got %0d expected 0", state); else passed++;
        lock_up("zero_lock");
        total++; if (zero_seen !== 1'b1) $display("FAIL zero_sticky: got %0b expected 1", zero_seen); else passed++;
        drive(1'b1, 6'd0, 1'b0);
        total++; if (err_pulse !== 1'b1) $display("FAIL zero_locked_pulse: got %0b expected 1", err_pulse); else passed++;
        total++; if (err_count !== 8'd1) $display("FAIL zero_locked_count: got %0d expected 1", err_count); else passed++;
        total++; if (state !== 2'd2) $display("FAIL zero_locked_state: got %0d expected 2", state); else passed++;
    endtask

    task automatic test_saturate_clear_reset();
        logic [5:0] pred;
        logic [5:0] bad;
        do_reset();
        lock_up("sat_lock");
        pred = 6'd55;
        for (int i = 0; i < 300; i++) begin
            bad = pred ^ 6'd1;
            if (bad == 6'd0) bad = pred ^ 6'd2;
            drive(1'b1, bad, 1'b0);
            pred = nxt(pred);
            drive(1'b1, pred, 1'b0);
            pred = nxt(pred);
        end
        total++; if (err_count !== 8'd255) $display("FAIL sat_count: got %0d expected 255", err_count); else passed++;
        total++; if (locked !== 1'b1) $display("FAIL sat_locked: got %0b expected 1", locked); else passed++;
        drive(1'b1, pred ^ 6'd1, 1'b1);
        pred = nxt(pred);
        total++; if (err_count !== 8'd0) $display("FAIL clear_count: got %0d expected 0", err_count); else passed++;
        total++; if (err_pulse !== 1'b0) $display("FAIL clear_pulse: got %0b expected 0", err_pulse); else passed++;
        total++; if (locked !== 1'b1) $display("FAIL clear_locked: got %0b expected 1", locked); else passed++;
        drive(1'b1, pred, 1'b0);
        pred = nxt(pred);
        drive(1'b1, pred ^ 6'd1, 1'b0);
        total++; if (err_count !== 8'd1) $display("FAIL pre_rst_count: got %0d expected 1", err_count); else passed++;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++; if (state !== 2'd0) $display("FAIL async_rst_state: got %0d expected 0", state); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL async_rst_locked: got %0b expected 0", locked); else passed++;
        total++; if (err_pulse !== 1'b0) $display("FAIL async_rst_pulse: got %0b expected 0", err_pulse); else passed++;
        total++; if (err_count !== 8'd0) $display("FAIL async_rst_count: got %0d expected 0", err_count); else passed++;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 6'd59, 1'b0);
        total++; if (state !== 2'd1) $display("FAIL post_rst_seed: got %0d expected 1", state); else passed++;
        total++; if (err_pulse !== 1'b0) $display("FAIL post_rst_pulse: got %0b expected 0", err_pulse); else passed++;
    endtask

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_value = 6'd0;
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_sync_reseed();
        test_idle();
        test_zero();
        test_saturate_clear_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
